jtag_confreg_sync: RTL and testbench



---
 rtl/jtag_confreg_sync.sv | 157 +++++++++++++++
 tb/tb_jtag_confreg_sync.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_confreg_sync.sv
// SoC-side consumer of the JTAG config byte: 2-flop sync, stability filter, buffered command, status return.
// Optional sticky overflow flag enabled by defining JTAG_CONFREG_SYNC_OVF_EN.
module jtag_confreg_sync #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] jtag_reg_async_i,
  output logic [WIDTH-1:0] jtag_reg_o,
  output logic             cmd_valid_o,
  input  logic             cmd_ready_i,
  output logic [WIDTH-1:0] cmd_data_o,
  input  logic [WIDTH-1:0] status_i,
  output logic [WIDTH-1:0] status_o,
  output logic             ovf_o
);

  localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_e;

  logic [WIDTH-1:0] s1_q, s2_q, cand_q, acc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             hs_c;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic [WIDTH-1:0] status_d, status_q;
  logic             unused_c;

  // Run length of the current s2 value, counting the cycle it first appeared.
  always_comb begin
    cnt_d = cnt_q;
    if (s2_q != cand_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign accept_c = (cnt_d == CNT_MAX) && (s2_q != acc_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= RESET_VALUE;
      s2_q   <= RESET_VALUE;
      cand_q <= RESET_VALUE;
      cnt_q  <= CNT_MAX;
      acc_q  <= RESET_VALUE;
    end else begin
      s1_q   <= jtag_reg_async_i;
      s2_q   <= s1_q;
      cand_q <= s2_q;
      cnt_q  <= cnt_d;
      if (accept_c) begin
        acc_q <= s2_q;
      end
    end
  end

  assign hs_c = cmd_ready_i && (state_q != ST_EMPTY);

  // Command slot plus one pending slot; pending coalesces to the newest value.
  always_comb begin
    state_d     = state_q;
    cmd_data_d  = cmd_data_q;
    pend_data_d = pend_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          cmd_data_d = s2_q;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept_c && hs_c) begin
          cmd_data_d = s2_q;
        end else if (accept_c) begin
          pend_data_d = s2_q;
          state_d     = ST_FULL;
        end else if (hs_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (hs_c) begin
          cmd_data_d = pend_data_q;
          if (accept_c) begin
            pend_data_d = s2_q;
          end else begin
            state_d = ST_BUSY;
          end
        end else if (accept_c) begin
          pend_data_d = s2_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      cmd_data_q  <= RESET_VALUE;
      pend_data_q <= RESET_VALUE;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_data_q  <= cmd_data_d;
      pend_data_q <= pend_data_d;
      status_q    <= status_d;
    end
  end

`ifdef JTAG_CONFREG_SYNC_OVF_EN
  logic ovf_q;
  logic ovf_set_c;

  assign ovf_set_c = (state_q == ST_FULL) && !cmd_ready_i && accept_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (ovf_set_c) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o    = ovf_q;
  assign unused_c = ^status_i[WIDTH-1:WIDTH-2];
`else
  assign ovf_o    = 1'b0;
  assign unused_c = status_i[WIDTH-1];
`endif

  // Top bit reports a pending command; next bit is overflow or passthrough.
  always_comb begin
    status_d            = '0;
    status_d[WIDTH-1]   = (state_q == ST_FULL);
`ifdef JTAG_CONFREG_SYNC_OVF_EN
    status_d[WIDTH-2]   = ovf_q;
`else
    status_d[WIDTH-2]   = status_i[WIDTH-2];
`endif
    status_d[WIDTH-3:0] = status_i[WIDTH-3:0];
  end

  assign jtag_reg_o  = acc_q;
  assign cmd_valid_o = (state_q != ST_EMPTY);
  assign cmd_data_o  = cmd_data_q;
  assign status_o    = status_q;

endmodule

// File: tb/tb_jtag_confreg_sync.sv
// Self-checking bench for jtag_confreg_sync: directed scenarios plus randomized traffic vs a queue model.
module tb_jtag_confreg_sync;

  localparam int unsigned W  = 8;
  localparam int unsigned S  = 4;
  localparam logic [7:0]  RV = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] async_in = 8'h00;
  logic [7:0] jtag_reg;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [7:0] cmd_data;
  logic [7:0] status_in = 8'h00;
  logic [7:0] status_out;
  logic       ovf;

  int checks = 0;
  int errors = 0;

`ifdef JTAG_CONFREG_SYNC_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  jtag_confreg_sync #(.WIDTH(W), .STABLE_CYCLES(S), .RESET_VALUE(RV)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .jtag_reg_async_i (async_in),
    .jtag_reg_o       (jtag_reg),
    .cmd_valid_o      (cmd_valid),
    .cmd_ready_i      (cmd_ready),
    .cmd_data_o       (cmd_data),
    .status_i         (status_in),
    .status_o         (status_out),
    .ovf_o            (ovf)
  );

  always #5 clk = ~clk;

  // Reference: samples seen by the synchronizer (newest first) and a two-entry command queue.
  logic [7:0] smp [0:S];
  logic [7:0] m_acc;
  logic [7:0] m_status;
  bit         m_ovf;
  logic [7:0] m_q [$];

  task automatic model_update();
    bit         run_ok;
    bit         ev;
    logic [7:0] v;
    if (rst) begin
      for (int i = 0; i <= S; i++) smp[i] = RV;
      m_acc    = RV;
      m_q.delete();
      m_ovf    = 1'b0;
      m_status = 8'h00;
    end else begin
      // A value is accepted once the last S synchronized samples agree and differ from the current value.
      run_ok = 1'b1;
      for (int i = 2; i <= S; i++) if (smp[i] !== smp[1]) run_ok = 1'b0;
      v  = smp[1];
      ev = run_ok && (v !== m_acc);
      m_status[7]   = (m_q.size() == 2);
      m_status[6]   = OVF_EN ? m_ovf : status_in[6];
      m_status[5:0] = status_in[5:0];
      if (cmd_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (ev) begin
        m_acc = v;
        m_q.push_back(v);
        if (m_q.size() > 2) begin
          m_q.delete(1);
          if (OVF_EN) m_ovf = 1'b1;
        end
      end
      for (int i = S; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = async_in;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [7:0] v, input int n);
    async_in = v;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    async_in  = RV;
    cmd_ready = 1'b0;
    status_in = 8'h00;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({jtag_reg, cmd_valid, cmd_data, status_out, ovf} !== {RV, 1'b0, RV, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got jtag=%h valid=%b data=%h status=%h ovf=%b, exp all zero",
               jtag_reg, cmd_valid, cmd_data, status_out, ovf);
    end
  endtask

  task automatic test_glitch();
    settle(8'h33, 3);
    async_in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (cmd_valid !== 1'b0 || jtag_reg !== 8'h00) begin
        errors++;
        $display("FAIL glitch_filtered cyc%0d: got valid=%b jtag=%h, exp valid=0 jtag=00", i, cmd_valid, jtag_reg);
      end
    end
  endtask

  task automatic test_accept();
    async_in = 8'h5A;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (k < 6 && (cmd_valid !== 1'b0 || jtag_reg !== 8'h00)) begin
        errors++;
        $display("FAIL accept_early edge%0d: got valid=%b jtag=%h, exp valid=0 jtag=00", k, cmd_valid, jtag_reg);
      end else if (k == 6 && {jtag_reg, cmd_valid, cmd_data} !== {8'h5A, 1'b1, 8'h5A}) begin
        errors++;
        $display("FAIL accept_edge6: got jtag=%h valid=%b data=%h, exp 5a 1 5a", jtag_reg, cmd_valid, cmd_data);
      end
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_handshake: got valid=%b, exp 0", cmd_valid);
    end
  endtask

  task automatic test_backlog();
    cmd_ready = 1'b0;
    settle(8'h01, 8);
    settle(8'h02, 8);
    settle(8'h03, 8);
    checks++;
    if ({cmd_valid, cmd_data, status_out[7], ovf} !== {1'b1, 8'h01, 1'b1, OVF_EN}) begin
      errors++;
      $display("FAIL backlog_full: got valid=%b data=%h pend=%b ovf=%b, exp 1 01 1 %b",
               cmd_valid, cmd_data, status_out[7], ovf, OVF_EN);
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    checks++;
    if ({cmd_valid, cmd_data} !== {1'b1, 8'h03}) begin
      errors++;
      $display("FAIL backlog_coalesced: got valid=%b data=%h, exp 1 03", cmd_valid, cmd_data);
    end
    step();
    checks++;
    if (status_out[7] !== 1'b0) begin
      errors++;
      $display("FAIL backlog_pending_clear: got %b, exp 0", status_out[7]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_ready = 1'b0;
    settle(8'h01, 8);
    settle(8'h02, 8);
    async_in = 8'h04;
    for (int i = 0; i < 5; i++) step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    checks++;
    if ({cmd_valid, cmd_data, ovf, jtag_reg} !== {1'b1, 8'h02, 1'b0, 8'h04}) begin
      errors++;
      $display("FAIL coincident_hs: got valid=%b data=%h ovf=%b jtag=%h, exp 1 02 0 04",
               cmd_valid, cmd_data, ovf, jtag_reg);
    end
    step();
    checks++;
    if (status_out[7] !== 1'b1) begin
      errors++;
      $display("FAIL coincident_pending: got %b, exp 1", status_out[7]);
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    checks++;
    if ({cmd_valid, cmd_data} !== {1'b1, 8'h04}) begin
      errors++;
      $display("FAIL coincident_drain: got valid=%b data=%h, exp 1 04", cmd_valid, cmd_data);
    end
  endtask

  task automatic test_reset_in_full();
    cmd_ready = 1'b0;
    settle(8'h05, 8);
    checks++;
    if (status_out[7] !== 1'b1) begin
      errors++;
      $display("FAIL rst_full_setup: got pending=%b, exp 1", status_out[7]);
    end
    async_in = RV;
    do_reset();
    checks++;
    if ({jtag_reg, cmd_valid, cmd_data, status_out, ovf} !== {RV, 1'b0, RV, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rst_full: got jtag=%h valid=%b data=%h status=%h ovf=%b, exp all zero",
               jtag_reg, cmd_valid, cmd_data, status_out, ovf);
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_value_no_event: got valid=%b, exp 0", cmd_valid);
    end
  endtask

  task automatic test_status();
    status_in = 8'hA5;
    step();
    checks++;
    if (status_out !== 8'h25) begin
      errors++;
      $display("FAIL status_pass: got %h, exp 25", status_out);
    end
    cmd_ready = 1'b0;
    settle(8'h11, 8);
    settle(8'h22, 8);
    settle(8'h33, 8);
    cmd_ready = 1'b1;
    step();
    step();
    cmd_ready = 1'b0;
    step();
    step();
    checks++;
    if (status_out !== (OVF_EN ? 8'h65 : 8'h25)) begin
      errors++;
      $display("FAIL status_ovf: got %h, exp %h", status_out, OVF_EN ? 8'h65 : 8'h25);
    end
  endtask

  task automatic test_random();
    int         hold;
    logic [7:0] pool [0:3];
    hold = 0;
    for (int i = 0; i < 4; i++) pool[i] = 8'($urandom);
    pool[0] = RV;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        async_in = pool[$urandom_range(3, 0)];
        hold     = ($urandom_range(3, 0) == 0) ? $urandom_range(4, 1) : $urandom_range(12, 5);
      end
      hold--;
      cmd_ready = ($urandom_range(3, 0) == 0);
      status_in = 8'($urandom);
      rst       = ($urandom_range(149, 0) == 0);
      step();
      checks++;
      if ({jtag_reg, cmd_valid, status_out, ovf} !== {m_acc, m_q.size() != 0, m_status, m_ovf}) begin
        errors++;
        $display("FAIL random cyc%0d: got jtag=%h valid=%b status=%h ovf=%b, exp %h %b %h %b",
                 c, jtag_reg, cmd_valid, status_out, ovf, m_acc, m_q.size() != 0, m_status, m_ovf);
      end
      if (m_q.size() != 0) begin
        checks++;
        if (cmd_data !== m_q[0]) begin
          errors++;
          $display("FAIL random_data cyc%0d: got %h, exp %h", c, cmd_data, m_q[0]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i <= S; i++) smp[i] = RV;
    m_acc    = RV;
    m_status = 8'h00;
    m_ovf    = 1'b0;
    test_reset();
    test_glitch();
    test_accept();
    test_backlog();
    test_back_to_back();
    test_reset_in_full();
    test_status();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
